// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared ALU control, opcode/fn enums and register indices for the multicycle MIPS core
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_NOR  = 4'b0011,
        ALU_ADDU = 4'b0100,
        ALU_SUBU = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLLV = 4'b1011,
        ALU_SRLV = 4'b1100,
        ALU_SRAV = 4'b1101,
        ALU_LUI  = 4'b1110,
        ALU_NOP  = 4'b1111
    } alu_ctrl_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_ADDIU = 6'b001001,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        FN_JR   = 6'b001000,
        FN_JALR = 6'b001001,
        FN_ADDU = 6'b100001
    } fn_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_cpu_alu_regs_if.sv
// rtl/mips_cpu_alu_regs_if.sv - controller-to-core bus: register file ports and ALU operands/result
interface mips_cpu_alu_regs_if;
    logic        writeEnable;
    logic [4:0]  writeaddress;
    logic [31:0] dataIn;
    logic [4:0]  readAdressA;
    logic [31:0] readDataA;
    logic [4:0]  readAddressB;
    logic [31:0] readDataB;
    logic [31:0] register_v0;
    logic [3:0]  control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] r;
    logic        zero;

    modport master (
        output writeEnable, writeaddress, dataIn, readAdressA, readAddressB,
        output control, a, b, sa,
        input  readDataA, readDataB, register_v0, r, zero
    );

    modport slave (
        input  writeEnable, writeaddress, dataIn, readAdressA, readAddressB,
        input  control, a, b, sa,
        output readDataA, readDataB, register_v0, r, zero
    );
endinterface

// File: rtl/mips_cpu_ALU.sv
// rtl/mips_cpu_ALU.sv - combinational 32-bit ALU with zero flag
module mips_cpu_ALU
    import mips_cpu_pkg::*;
(
    input  logic [3:0]  control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sa,
    output logic [31:0] r,
    output logic        zero
);

    always_comb begin
        r = '0;
        case (alu_ctrl_t'(control))
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_ADDU: r = a + b;
            ALU_SUBU: r = a - b;
            ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'b0, (a < b)};
            ALU_SLL:  r = b << sa;
            ALU_SRL:  r = b >> sa;
            ALU_SRA:  r = $signed(b) >>> sa;
            ALU_SLLV: r = b << a[4:0];
            ALU_SRLV: r = b >> a[4:0];
            ALU_SRAV: r = $signed(b) >>> a[4:0];
            ALU_LUI:  r = {b[15:0], 16'h0000};
            ALU_NOP:  r = '0;
            default:  r = '0;
        endcase
    end

    assign zero = (r == '0);

endmodule

// File: rtl/mips_cpu_registers.sv
// rtl/mips_cpu_registers.sv - 32x32 register file, two combinational reads, one synchronous write
module mips_cpu_registers
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEnable,
    input  logic [4:0]  writeaddress,
    input  logic [31:0] dataIn,
    input  logic [4:0]  readAdressA,
    output logic [31:0] readDataA,
    input  logic [4:0]  readAddressB,
    output logic [31:0] readDataB,
    output logic [31:0] register_v0
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (writeEnable && (writeaddress != REG_ZERO)) begin
            regs_d[writeaddress] = dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come straight from the array: a same-cycle write is not forwarded.
    assign readDataA   = (readAdressA  == REG_ZERO) ? '0 : regs_q[readAdressA];
    assign readDataB   = (readAddressB == REG_ZERO) ? '0 : regs_q[readAddressB];
    assign register_v0 = regs_q[REG_V0];

endmodule

// File: rtl/mips_cpu_alu_regs.sv
// rtl/mips_cpu_alu_regs.sv - execution core wrapper: register file plus ALU behind one bus interface
module mips_cpu_alu_regs (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_alu_regs_if.slave bus
);

    mips_cpu_registers u_registers (
        .clk          (clk),
        .reset        (reset),
        .writeEnable  (bus.writeEnable),
        .writeaddress (bus.writeaddress),
        .dataIn       (bus.dataIn),
        .readAdressA  (bus.readAdressA),
        .readDataA    (bus.readDataA),
        .readAddressB (bus.readAddressB),
        .readDataB    (bus.readDataB),
        .register_v0  (bus.register_v0)
    );

    mips_cpu_ALU u_alu (
        .control (bus.control),
        .a       (bus.a),
        .b       (bus.b),
        .sa      (bus.sa),
        .r       (bus.r),
        .zero    (bus.zero)
    );

endmodule

// File: tb/tb_mips_cpu_alu_regs.sv
// tb/tb_mips_cpu_alu_regs.sv - self-checking bench for mips_cpu_alu_regs against a behavioural model
module tb_mips_cpu_alu_regs;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] model_regs [32];

    mips_cpu_alu_regs_if bus ();

    mips_cpu_alu_regs dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [4:0] s);
        longint unsigned uy;
        longint          sy;
        logic [4:0]      amt;
        uy  = {32'b0, y};
        sy  = longint'(int'(y));
        amt = (op >= 4'd11 && op <= 4'd13) ? x[4:0] : s;
        case (op)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x ^ y;
            4'd3:  return ~(x | y);
            4'd4:  return 32'(uy + {32'b0, x});
            4'd5:  return 32'({32'b0, x} - uy);
            4'd6:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd7:  return (x < y) ? 32'd1 : 32'd0;
            4'd8, 4'd11:  return 32'(uy * (64'd1 << amt));
            4'd9, 4'd12:  return 32'(uy / (64'd1 << amt));
            4'd10, 4'd13: return 32'(sy >>> amt);
            4'd14: return 32'(uy * 64'd65536);
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] s, input logic [31:0] exp_r);
        bus.control = op;
        bus.a       = x;
        bus.b       = y;
        bus.sa      = s;
        #1;
        check({tag, "_r"}, bus.r, exp_r);
        check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, (exp_r == 32'd0)});
    endtask

    initial begin
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  s;
        logic [31:0] exp_r;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.writeEnable  = 1'b0;
        bus.writeaddress = 5'd0;
        bus.dataIn       = 32'd0;
        bus.readAdressA  = 5'd2;
        bus.readAddressB = 5'd3;
        bus.control      = 4'hF;
        bus.a            = 32'd0;
        bus.b            = 32'd0;
        bus.sa           = 5'd0;

        // Reset held with no clock edge yet.
        #3;
        check("rst_readA", bus.readDataA, 32'd0);
        check("rst_readB", bus.readDataB, 32'd0);
        check("rst_v0", bus.register_v0, 32'd0);
        #4 reset = 1'b1;

        // Write 5 to reg 3, then asynchronous reset clears it immediately.
        bus.writeEnable  = 1'b1;
        bus.writeaddress = 5'd3;
        bus.dataIn       = 32'd5;
        bus.readAdressA  = 5'd3;
        tick();
        check("wr_reg3", bus.readDataA, 32'd5);
        bus.writeEnable = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_reg3", bus.readDataA, 32'd0);
        #1 reset = 1'b1;

        // Write 0xDEADBEEF to reg 2: old value visible until the edge.
        tick();
        bus.writeEnable  = 1'b1;
        bus.writeaddress = 5'd2;
        bus.dataIn       = 32'hDEADBEEF;
        bus.readAdressA  = 5'd2;
        #1;
        check("pre_edge_readA", bus.readDataA, 32'd0);
        check("pre_edge_v0", bus.register_v0, 32'd0);
        tick();
        check("post_edge_readA", bus.readDataA, 32'hDEADBEEF);
        check("post_edge_v0", bus.register_v0, 32'hDEADBEEF);

        // Writes to reg 0 are discarded.
        bus.writeaddress = 5'd0;
        bus.dataIn       = 32'hFFFFFFFF;
        bus.readAdressA  = 5'd0;
        tick();
        check("reg0_write", bus.readDataA, 32'd0);

        // writeEnable low changes nothing.
        bus.writeEnable  = 1'b0;
        bus.writeaddress = 5'd5;
        bus.dataIn       = 32'h1234;
        bus.readAddressB = 5'd5;
        tick();
        check("we0_reg5", bus.readDataB, 32'd0);

        alu_vec("addu_wrap", 4'b0100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0);
        alu_vec("subu", 4'b0101, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE);
        alu_vec("slt", 4'b0110, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1);
        alu_vec("sltu", 4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0);
        alu_vec("sra", 4'b1010, 32'd0, 32'h80000000, 5'd4, 32'hF8000000);
        alu_vec("srl", 4'b1001, 32'd0, 32'h80000000, 5'd4, 32'h08000000);
        alu_vec("sllv", 4'b1011, 32'h21, 32'd1, 5'd0, 32'h2);
        alu_vec("lui", 4'b1110, 32'd0, 32'h1234, 5'd0, 32'h12340000);
        alu_vec("nop", 4'b1111, 32'h13579BDF, 32'h2468ACE0, 5'd7, 32'd0);
        alu_vec("and", 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0);
        alu_vec("or", 4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0);
        alu_vec("xor", 4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00);
        alu_vec("nor", 4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h000F000F);

        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_regs[2] = 32'hDEADBEEF;

        // Randomized register traffic and ALU operations against the model.
        for (int it = 0; it < 400; it++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom);
            wd = (($urandom & 7) == 0) ? 32'd0 : $urandom;
            ra = (($urandom & 3) == 0) ? wa : 5'($urandom);
            rb = 5'($urandom);
            bus.writeEnable  = we;
            bus.writeaddress = wa;
            bus.dataIn       = wd;
            bus.readAdressA  = ra;
            bus.readAddressB = rb;

            op = 4'($urandom);
            x  = (($urandom & 3) == 0) ? y : $urandom;
            y  = (($urandom & 7) == 0) ? 32'h80000000 : $urandom;
            s  = 5'($urandom);
            exp_r = ref_alu(op, x, y, s);
            alu_vec($sformatf("rnd_alu_op%0d", op), op, x, y, s, exp_r);

            check("rnd_readA", bus.readDataA, model_regs[ra]);
            check("rnd_readB", bus.readDataB, model_regs[rb]);
            tick();
            if (we && wa != 5'd0) model_regs[wa] = wd;
            check("rnd_post_readA", bus.readDataA, model_regs[ra]);
            check("rnd_v0", bus.register_v0, model_regs[2]);
        end

        // Final asynchronous reset clears everything.
        bus.writeEnable = 1'b0;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i += 5) begin
            bus.readAdressA = 5'(i);
            #1;
            check($sformatf("final_rst_reg%0d", i), bus.readDataA, 32'd0);
        end
        check("final_rst_v0", bus.register_v0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
